// File: rtl/multi_key_debounce.sv
// N-channel key debouncer: 2-flop sync, tick-based debounce, press/release pulses,
// and a round-robin valid/ready event stream carrying one key code per transfer.
module multi_key_debounce #(
    parameter int N_KEYS      = 8,
    parameter int CLK_FREQ_HZ = 48_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int ACTIVE_LOW  = 1,
    localparam int KW         = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KW-1:0]     evt_key,
    output logic              evt_press,
    output logic              evt_overflow
);

    // Event handshake: the event register holds {evt_key, evt_press} while
    // evt_valid is high; a transfer happens on every clock where
    // evt_valid && evt_ready, and the register may reload in that same cycle.

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_MS - 1);
    localparam logic [N_KEYS-1:0] IDLE   = {N_KEYS{ACTIVE_LOW != 0}};

    logic [N_KEYS-1:0]         sync1_q, sync2_q, pressed;
    logic [PW-1:0]             presc_q, presc_d;
    logic                      tick;
    logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_KEYS-1:0]         state_q, state_d;
    logic [N_KEYS-1:0]         press_q, press_d, rel_q, rel_d;
    logic [N_KEYS-1:0]         ppend_q, ppend_d, rpend_q, rpend_d;
    logic [N_KEYS-1:0]         order_q, order_d;
    logic                      ovf_q, ovf_d;
    logic                      evt_valid_q;
    logic [KW-1:0]             evt_key_q;
    logic                      evt_press_q;
    logic [KW-1:0]             last_q;

    logic [N_KEYS-1:0]         pend, sel_oh, clr_press, clr_rel, pp_c, rp_c;
    logic                      any_pend, load, take, sel_press;
    logic [KW-1:0]             sel_idx;
    int                        rr_idx;

    assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < N_KEYS; i++) begin
            if (pressed[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    state_d[i] = pressed[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press_d = state_d & ~state_q;
    assign rel_d   = ~state_d & state_q;

    // Round-robin search starting one past the last granted channel.
    assign pend = ppend_q | rpend_q;
    always_comb begin
        any_pend = 1'b0;
        sel_idx  = '0;
        rr_idx   = 0;
        for (int k = 0; k < N_KEYS; k++) begin
            rr_idx = int'(last_q) + 1 + k;
            if (rr_idx >= N_KEYS) rr_idx = rr_idx - N_KEYS;
            if (!any_pend && pend[rr_idx]) begin
                any_pend = 1'b1;
                sel_idx  = KW'(rr_idx);
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_KEYS; i++) sel_oh[i] = (KW'(i) == sel_idx);
    end

    // order_q[i] = 1 means the press flag is the older of the two.
    assign sel_press = (ppend_q[sel_idx] && rpend_q[sel_idx]) ? order_q[sel_idx]
                                                              : ppend_q[sel_idx];
    assign load      = !evt_valid_q || evt_ready;
    assign take      = load && any_pend;
    assign clr_press = (take && sel_press)  ? sel_oh : '0;
    assign clr_rel   = (take && !sel_press) ? sel_oh : '0;

    assign pp_c    = ppend_q & ~clr_press;
    assign rp_c    = rpend_q & ~clr_rel;
    assign ppend_d = pp_c | press_d;
    assign rpend_d = rp_c | rel_d;
    assign ovf_d   = ovf_q | (|(press_d & ppend_q)) | (|(rel_d & rpend_q));

    always_comb begin
        order_d = order_q;
        for (int i = 0; i < N_KEYS; i++) begin
            if (pp_c[i] && rp_c[i]) order_d[i] = order_q[i];
            else if (pp_c[i])       order_d[i] = 1'b1;
            else if (rp_c[i])       order_d[i] = 1'b0;
            else                    order_d[i] = press_d[i];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q     <= IDLE;
            sync2_q     <= IDLE;
            presc_q     <= '0;
            cnt_q       <= '0;
            state_q     <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            ppend_q     <= '0;
            rpend_q     <= '0;
            order_q     <= '0;
            ovf_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_press_q <= 1'b0;
            last_q      <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            ppend_q <= ppend_d;
            rpend_q <= rpend_d;
            order_q <= order_d;
            ovf_q   <= ovf_d;
            if (load) evt_valid_q <= any_pend;
            if (take) begin
                evt_key_q   <= sel_idx;
                evt_press_q <= sel_press;
                last_q      <= sel_idx;
            end
        end
    end

    assign key_state     = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign evt_valid     = evt_valid_q;
    assign evt_key       = evt_key_q;
    assign evt_press     = evt_press_q;
    assign evt_overflow  = ovf_q;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench for multi_key_debounce: 4 clk/tick, 3-tick debounce, 8 active-low keys.
module tb_multi_key_debounce;

    localparam int N  = 8;
    localparam int KW = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [N-1:0]  key_in  = '1;
    logic [N-1:0]  key_state, press_pulse, release_pulse;
    logic          evt_valid, evt_ready = 1'b1;
    logic [KW-1:0] evt_key;
    logic          evt_press, evt_overflow;

    int checks = 0;
    int errors = 0;
    int evt_rd = 0;
    int n;
    logic [3:0]   evt_q[$];
    logic [3:0]   exp_q[$];
    logic [N-1:0] acc_state, acc_press, acc_rel;
    int           acc_valid;

    multi_key_debounce #(
        .N_KEYS(N), .CLK_FREQ_HZ(4000), .DEBOUNCE_MS(3), .ACTIVE_LOW(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
        .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_press(evt_press), .evt_overflow(evt_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Transfers seen on the event port, encoded {press, key}.
    always @(negedge sys_clk) begin
        if (!sys_rst && evt_valid && evt_ready) evt_q.push_back({evt_press, evt_key});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        acc_state |= key_state;
        acc_press |= press_pulse;
        acc_rel   |= release_pulse;
        if (evt_valid) acc_valid++;
    endtask

    task automatic clear_acc();
        acc_state = '0;
        acc_press = '0;
        acc_rel   = '0;
        acc_valid = 0;
    endtask

    task automatic reset_pulse(input string tag);
        sys_rst = 1'b1;
        step();
        check(tag, 32'({key_state, press_pulse, release_pulse, evt_valid, evt_key,
                        evt_press, evt_overflow}), 32'd0);
        step();
        sys_rst = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        key_in    = '1;
        evt_ready = 1'b1;
        reset_pulse(tag);
        clear_acc();
    endtask

    task automatic wait_state(input int idx, input logic val, output int cnt);
        cnt = 0;
        while (key_state[idx] !== val && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (evt_valid !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_cnt"}, 32'(evt_q.size() - evt_rd), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (evt_rd + i < evt_q.size()) check(tag, 32'(evt_q[evt_rd + i]), 32'(exp_q[i]));
        end
        evt_rd = evt_q.size();
        exp_q.delete();
    endtask

    initial begin
        clear_acc();
        do_reset("rst0");

        // 1: single clean press with ready high
        key_in[0] = 1'b0;
        wait_state(0, 1'b1, n);
        check("t1_state", 32'(key_state[0]), 32'd1);
        check("t1_lat", 32'(n >= 10 && n <= 14), 32'd1);
        check("t1_pulse", 32'(press_pulse), 32'h01);
        check("t1_nvalid", 32'(evt_valid), 32'd0);
        step();
        check("t1_pulse_off", 32'(press_pulse), 32'd0);
        check("t1_evt", 32'({evt_valid, evt_press, evt_key}), 32'h18);
        step();
        check("t1_valid_off", 32'(evt_valid), 32'd0);
        exp_q.push_back(4'h8);
        repeat (3) step();
        compare_events("t1_evq");

        // 2: bouncing key settles low
        do_reset("rst2");
        for (int t = 0; t < 8; t++) begin
            key_in[1] = ~key_in[1];
            repeat (5) step();
        end
        key_in[1] = 1'b0;
        repeat (40) step();
        check("t2_state", 32'(key_state), 32'h02);
        check("t2_press", 32'(acc_press), 32'h02);
        check("t2_rel", 32'(acc_rel), 32'd0);
        check("t2_vcnt", 32'(acc_valid), 32'd1);
        check("t2_ovf", 32'(evt_overflow), 32'd0);
        exp_q.push_back(4'h9);
        compare_events("t2_evq");

        // 3: short glitch must be rejected
        do_reset("rst3");
        key_in[2] = 1'b0;
        repeat (6) step();
        key_in[2] = 1'b1;
        repeat (30) step();
        check("t3_state", 32'(acc_state), 32'd0);
        check("t3_pulses", 32'({acc_press, acc_rel}), 32'd0);
        check("t3_valid", 32'(acc_valid), 32'd0);
        compare_events("t3_evq");

        // 4: simultaneous presses, backpressure, then round-robin drain
        do_reset("rst4");
        evt_ready = 1'b0;
        key_in[2] = 1'b0;
        key_in[5] = 1'b0;
        key_in[7] = 1'b0;
        wait_valid(n);
        check("t4_valid", 32'(evt_valid), 32'd1);
        check("t4_first", 32'({evt_press, evt_key}), 32'hA);
        repeat (5) step();
        check("t4_hold", 32'({evt_valid, evt_press, evt_key}), 32'h1A);
        evt_ready = 1'b1;
        step();
        check("t4_second", 32'({evt_valid, evt_press, evt_key}), 32'h1D);
        step();
        check("t4_third", 32'({evt_valid, evt_press, evt_key}), 32'h1F);
        step();
        check("t4_empty", 32'(evt_valid), 32'd0);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hD);
        exp_q.push_back(4'hF);
        compare_events("t4_evq");

        // 5: repeated edges on one key while stalled -> overflow, age order kept
        do_reset("rst5");
        evt_ready = 1'b0;
        key_in[3] = 1'b0;
        wait_state(3, 1'b1, n);
        check("t5_p1", 32'(key_state[3]), 32'd1);
        repeat (3) step();
        key_in[3] = 1'b1;
        wait_state(3, 1'b0, n);
        check("t5_r1", 32'(key_state[3]), 32'd0);
        repeat (3) step();
        key_in[3] = 1'b0;
        wait_state(3, 1'b1, n);
        check("t5_p2", 32'(key_state[3]), 32'd1);
        repeat (3) step();
        check("t5_ovf_pre", 32'(evt_overflow), 32'd0);
        key_in[3] = 1'b1;
        wait_state(3, 1'b0, n);
        check("t5_r2", 32'(key_state[3]), 32'd0);
        repeat (3) step();
        check("t5_ovf", 32'(evt_overflow), 32'd1);
        check("t5_held", 32'({evt_valid, evt_press, evt_key}), 32'h1B);
        evt_ready = 1'b1;
        repeat (4) step();
        check("t5_empty", 32'(evt_valid), 32'd0);
        check("t5_ovf_sticky", 32'(evt_overflow), 32'd1);
        exp_q.push_back(4'hB);
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hB);
        compare_events("t5_evq");

        // 6: reset in the middle of a debounce restarts it cleanly
        do_reset("rst6");
        key_in[4] = 1'b0;
        repeat (6) step();
        reset_pulse("t6_rst");
        clear_acc();
        wait_valid(n);
        check("t6_lat", 32'(n), 32'd13);
        check("t6_evt", 32'({evt_valid, evt_press, evt_key}), 32'h1C);
        repeat (20) step();
        check("t6_state", 32'(key_state), 32'h10);
        check("t6_vcnt", 32'(acc_valid), 32'd1);
        exp_q.push_back(4'hC);
        compare_events("t6_evq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
